// File: rtl/apb_master_bridge.sv
// APB-style master bridge: turns a valid/ready command stream into single bus
// transfers with a wait-state timeout, and returns one held response per command.
module apb_master_bridge #(
    parameter int unsigned addrWidth = 32,
    parameter int unsigned dataWidth = 32,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    // command stream
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [addrWidth-1:0] cmd_addr,
    input  logic [dataWidth-1:0] cmd_wdata,
    // bus to slave
    output logic                 sel,
    output logic                 write,
    output logic [addrWidth-1:0] addr,
    output logic [dataWidth-1:0] wdata,
    input  logic [dataWidth-1:0] rdata,
    input  logic                 ready,
    input  logic                 err,
    // response stream
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [dataWidth-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic                 rsp_tmo
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e                 state_q, state_d;
    logic                   sel_q, sel_d;
    logic                   write_q, write_d;
    logic [addrWidth-1:0]   addr_q, addr_d;
    logic [dataWidth-1:0]   wdata_q, wdata_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [dataWidth-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                   rsp_err_q, rsp_err_d;
    logic                   rsp_tmo_q, rsp_tmo_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   tmo_hit;

    assign tmo_hit = (cnt_q == CntMax);

    // State and datapath registers, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            sel_q       <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_tmo_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_tmo_q   <= rsp_tmo_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state: IDLE -> ACCESS -> RESP -> IDLE; ready wins over timeout
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (cmd_valid) state_d = StAccess;
            StAccess: if (ready || tmo_hit) state_d = StResp;
            StResp:   if (rsp_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Bus and response register updates per state
    always_comb begin
        sel_d       = sel_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_tmo_d   = rsp_tmo_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    sel_d   = 1'b1;
                    write_d = cmd_write;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    cnt_d   = '0;
                end
            end
            StAccess: begin
                if (ready) begin
                    sel_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err;
                    rsp_tmo_d   = 1'b0;
                    // rdata may be undriven during writes, so never look at it then
                    rsp_rdata_d = write_q ? '0 : rdata;
                end else if (tmo_hit) begin
                    sel_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_tmo_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready) rsp_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Outputs come straight from registers except the idle-only command ready
    always_comb begin
        cmd_ready = (state_q == StIdle);
        sel       = sel_q;
        write     = write_q;
        addr      = addr_q;
        wdata     = wdata_q;
        rsp_valid = rsp_valid_q;
        rsp_rdata = rsp_rdata_q;
        rsp_err   = rsp_err_q;
        rsp_tmo   = rsp_tmo_q;
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with a small behavioural slave.
module tb_apb_master_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        sel, write;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        ready, err;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err, rsp_tmo;

    int n_checks = 0;
    int n_fail   = 0;

    // slave controls and bus observers
    int          wait_n   = 0;
    logic        slave_en = 1'b1;
    int          wcnt;
    logic [31:0] mem [256];
    int          sel_cnt = 0;
    int          rdy_cnt = 0;

    apb_master_bridge #(
        .addrWidth(32),
        .dataWidth(32),
        .TIMEOUT  (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .sel      (sel),
        .write    (write),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready),
        .err      (err),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .rsp_tmo  (rsp_tmo)
    );

    always #5 clk = ~clk;

    // Slave: 256 words, err above that, wait_n wait states, one-cycle ready pulse
    always @(posedge clk) begin
        if (rst) begin
            ready <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
            wcnt  <= 0;
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (sel && !ready && slave_en) begin
            if (wcnt == wait_n) begin
                ready <= 1'b1;
                wcnt  <= 0;
                if (addr >= 32'd256) begin
                    err   <= 1'b1;
                    rdata <= '0;
                end else begin
                    err <= 1'b0;
                    if (write) begin
                        mem[addr[7:0]] <= wdata;
                        rdata          <= 'x;
                    end else begin
                        rdata <= mem[addr[7:0]];
                    end
                end
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            wcnt  <= 0;
        end
    end

    // Count select cycles and ready pulses seen during select
    always @(posedge clk) begin
        if (sel) sel_cnt <= sel_cnt + 1;
        if (sel && ready) rdy_cnt <= rdy_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        check_eq("cmd_ready_idle", {63'd0, cmd_ready}, 64'd1);
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check_eq("sel_rise", {63'd0, sel}, 64'd1);
        check_eq("bus_addr", {32'd0, addr}, {32'd0, a});
        check_eq("bus_write", {63'd0, write}, {63'd0, w});
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 40 && !rsp_valid; i++) @(negedge clk);
        check_eq("rsp_arrived", {63'd0, rsp_valid}, 64'd1);
    endtask

    // Full transaction with response checks and an immediate handshake
    task automatic run_cmd(input string tag, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input int waits, input logic en,
                           input logic [31:0] exp_rdata, input logic exp_err,
                           input logic exp_tmo, input int exp_sel);
        wait_n   = waits;
        slave_en = en;
        @(negedge clk);
        sel_cnt = 0;
        rdy_cnt = 0;
        send_cmd(w, a, d);
        wait_rsp();
        check_eq({tag, "_sel_low"}, {63'd0, sel}, 64'd0);
        check_eq({tag, "_sel_cycles"}, 64'(sel_cnt), 64'(exp_sel));
        check_eq({tag, "_ready_pulses"}, 64'(rdy_cnt), en ? 64'd1 : 64'd0);
        check_eq({tag, "_rdata"}, {32'd0, rsp_rdata}, {32'd0, exp_rdata});
        check_eq({tag, "_err"}, {63'd0, rsp_err}, {63'd0, exp_err});
        check_eq({tag, "_tmo"}, {63'd0, rsp_tmo}, {63'd0, exp_tmo});
        check_eq({tag, "_cmd_ready_resp"}, {63'd0, cmd_ready}, 64'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq({tag, "_rsp_drop"}, {63'd0, rsp_valid}, 64'd0);
        check_eq({tag, "_back_idle"}, {63'd0, cmd_ready}, 64'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_sel"}, {63'd0, sel}, 64'd0);
        check_eq({tag, "_write"}, {63'd0, write}, 64'd0);
        check_eq({tag, "_addr"}, {32'd0, addr}, 64'd0);
        check_eq({tag, "_wdata"}, {32'd0, wdata}, 64'd0);
        check_eq({tag, "_rsp_valid"}, {63'd0, rsp_valid}, 64'd0);
        check_eq({tag, "_rsp_rdata"}, {32'd0, rsp_rdata}, 64'd0);
        check_eq({tag, "_rsp_err"}, {63'd0, rsp_err}, 64'd0);
        check_eq({tag, "_rsp_tmo"}, {63'd0, rsp_tmo}, 64'd0);
        check_eq({tag, "_cmd_ready"}, {63'd0, cmd_ready}, 64'd1);
    endtask

    initial begin
        logic [31:0] held_rdata;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset");

        // tag, write, addr, wdata, waits, slave_en, rdata, err, tmo, sel cycles
        run_cmd("wr10", 1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b1, 32'h0, 1'b0, 1'b0, 2);
        run_cmd("rd10", 1'b0, 32'h10, 32'h0, 0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 2);
        run_cmd("wr13", 1'b1, 32'h13, 32'h0BADF00D, 0, 1'b1, 32'h0, 1'b0, 1'b0, 2);
        run_cmd("rd13", 1'b0, 32'h13, 32'h0, 3, 1'b1, 32'h0BADF00D, 1'b0, 1'b0, 5);
        run_cmd("rd400", 1'b0, 32'h400, 32'h0, 0, 1'b1, 32'h0, 1'b1, 1'b0, 2);
        run_cmd("tmo", 1'b0, 32'h10, 32'h0, 0, 1'b0, 32'h0, 1'b1, 1'b1, 16);
        // ready lands on the same edge the timeout would fire: ready wins
        run_cmd("edge", 1'b0, 32'h10, 32'h0, 14, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 16);
        check_eq("bus_regs_kept", {32'd0, addr}, 64'h10);

        // Response held against a stalled consumer, then reset discards it
        wait_n   = 0;
        slave_en = 1'b1;
        send_cmd(1'b0, 32'h13, 32'h0);
        wait_rsp();
        held_rdata = rsp_rdata;
        check_eq("hold_rdata", {32'd0, held_rdata}, 64'h0BADF00D);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("hold_valid", {63'd0, rsp_valid}, 64'd1);
            check_eq("hold_stable", {32'd0, rsp_rdata}, {32'd0, held_rdata});
            check_eq("hold_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("rst_resp");

        // Reset in the middle of an access drops select at that edge
        slave_en = 1'b0;
        send_cmd(1'b1, 32'h20, 32'h12345678);
        repeat (3) @(negedge clk);
        check_eq("mid_sel_high", {63'd0, sel}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("rst_access");
        repeat (3) @(negedge clk);
        check_eq("no_rsp_after_rst", {63'd0, rsp_valid}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
